// File: rtl/udma_hyper_pkg.sv
// Shared uDMA HyperBus definitions.
// Default datapath widths and the RX packer state encoding.
package udma_hyper_pkg;

  localparam int HW_W   = 16;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/hyper_rx_packer.sv
// Packs received halfwords into 32-bit words with byte enables.
// Handles an odd start byte, a partial tail and a stalling consumer.
module hyper_rx_packer
  import udma_hyper_pkg::*;
#(
  parameter int IN_WIDTH  = HW_W,
  parameter int OUT_WIDTH = WORD_W,
  parameter int LEN_WIDTH = LEN_W
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 odd_i,
  input  logic [IN_WIDTH-1:0]  rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic [3:0]           be_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int ACC_W = OUT_WIDTH + 8;

  state_e               state_q, state_n;
  logic [LEN_WIDTH-1:0] rem_q, rem_n;
  logic                 skip_q, skip_n;
  logic [ACC_W-1:0]     acc_q, acc_n, acc_b;
  logic [2:0]           cnt_q, cnt_n, cnt_b;
  logic [OUT_WIDTH-1:0] data_q, data_n;
  logic [3:0]           be_q, be_n;
  logic                 last_q, last_n;
  logic                 valid_q, valid_n;
  logic                 out_free, mv;
  logic [1:0]           avail, nb;
  logic [IN_WIDTH-1:0]  add;

  assign out_free = !valid_q || ready_i;
  assign data_o   = data_q;
  assign be_o     = be_q;
  assign last_o   = last_q;
  assign valid_o  = valid_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    rx_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    rem_n      = rem_q;
    skip_n     = skip_q;
    acc_n      = acc_q;
    cnt_n      = cnt_q;
    data_n     = data_q;
    be_n       = be_q;
    last_n     = last_q;
    valid_n    = valid_q && !ready_i;
    avail      = skip_q ? 2'd1 : 2'd2;
    nb         = (rem_q < LEN_WIDTH'(avail)) ? rem_q[1:0] : avail;
    mv         = 1'b0;
    acc_b      = acc_q;
    cnt_b      = cnt_q;
    add        = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_n = RUN;
            rem_n   = len_i;
            skip_n  = odd_i;
            acc_n   = '0;
            cnt_n   = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN, FLUSH: begin
        busy_o     = 1'b1;
        rx_ready_o = (state_q == RUN) && (rem_q != '0)
                     && out_free && !clr_i;
        // a full word leaves while the next halfword lands behind it
        mv    = (cnt_q >= 3'd4) && out_free;
        acc_b = mv ? (acc_q >> OUT_WIDTH) : acc_q;
        cnt_b = mv ? (cnt_q - 3'd4) : cnt_q;
        acc_n = acc_b;
        cnt_n = cnt_b;
        if (mv) begin
          data_n  = acc_q[OUT_WIDTH-1:0];
          be_n    = 4'hf;
          last_n  = (state_q == FLUSH) && (cnt_q == 3'd4);
          valid_n = 1'b1;
        end
        if (rx_ready_o && rx_valid_i) begin
          add = (nb == 2'd2) ? rx_data_i :
                IN_WIDTH'(skip_q ? rx_data_i[15:8] : rx_data_i[7:0]);
          acc_n  = acc_b | (ACC_W'(add) << {cnt_b, 3'b000});
          cnt_n  = cnt_b + {1'b0, nb};
          rem_n  = rem_q - LEN_WIDTH'(nb);
          skip_n = 1'b0;
          if (rem_n == '0) state_n = FLUSH;
        end
        if ((state_q == FLUSH) && !mv && out_free) begin
          if (cnt_q != 3'd0) begin
            data_n  = acc_q[OUT_WIDTH-1:0];
            be_n    = 4'((5'd1 << cnt_q) - 5'd1);
            last_n  = 1'b1;
            valid_n = 1'b1;
            acc_n   = '0;
            cnt_n   = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        done_o  = !clr_i;
        state_n = IDLE;
      end
    endcase
    if (clr_i) begin
      state_n = IDLE;
      valid_n = 1'b0;
      rem_n   = '0;
      skip_n  = 1'b0;
      acc_n   = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rem_q   <= '0;
      skip_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_n;
      skip_q  <= skip_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      be_q    <= be_n;
      last_q  <= last_n;
      valid_q <= valid_n;
    end
  end

endmodule

// File: tb/tb_hyper_rx_packer.sv
// Self-checking bench for hyper_rx_packer.
// Expected words come from a byte-queue model of each transfer.
module tb_hyper_rx_packer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        clr_i;
  logic        start_i;
  logic [15:0] len_i;
  logic        odd_i;
  logic [15:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [31:0] data_o;
  logic [3:0]  be_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;

  hyper_rx_packer dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (clr_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .odd_i      (odd_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .data_o     (data_o),
    .be_o       (be_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        l;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] src_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rx_cnt, done_cnt, out_cnt, rdy_seen, vld_seen;
  bit          rx_hs;
  logic        pv = 0, pr = 0, pl = 0, pclr = 1;
  logic [31:0] pd = 0;
  logic [3:0]  pb = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int j = 0; j < 4; j++) if (be[j]) m[8*j +: 8] = 8'hff;
    return m;
  endfunction

  always @(negedge clk_i) begin
    ent_t e;
    rx_hs = 0;
    if (rstn_i) begin
      if (rx_valid_i && rx_ready_o) begin
        rx_hs = 1;
        rx_cnt++;
      end
      if (done_o) done_cnt++;
      if (rx_ready_o) rdy_seen++;
      if (valid_o) vld_seen++;
      if (valid_o && ready_i) begin
        out_cnt++;
        chk("word_pending", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("word_data", data_o & lane_mask(e.be), e.d);
          chk("word_be", be_o, e.be);
          chk("word_last", last_o, e.l);
        end
      end
      if (pv && !pr && !pclr) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, pd);
        chk("hold_be", be_o, pb);
        chk("hold_last", last_o, pl);
      end
      if (valid_o && !ready_i) chk("stall_rx_ready", rx_ready_o, 0);
    end
    pv   = valid_o;
    pr   = ready_i;
    pd   = data_o;
    pb   = be_o;
    pl   = last_o;
    pclr = clr_i || !rstn_i;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Flatten halfwords into bytes, apply skip and length, cut into words.
  task automatic build_model(input int len, input bit odd,
                             output int need);
    logic [7:0] b[$];
    ent_t       e;
    logic [15:0] h;
    exp_q.delete();
    foreach (src_q[i]) begin
      h = src_q[i];
      b.push_back(h[7:0]);
      b.push_back(h[15:8]);
    end
    if (odd) void'(b.pop_front());
    while (b.size() > len) void'(b.pop_back());
    need = (len == 0) ? 0 : (len + int'(odd) + 1) / 2;
    for (int k = 0; k < len; k += 4) begin
      e.d  = '0;
      e.be = '0;
      for (int j = 0; j < 4; j++)
        if (k + j < len) begin
          e.d[8*j +: 8] = b[k+j];
          e.be[j] = 1'b1;
        end
      e.l = (k + 4 >= len);
      exp_q.push_back(e);
    end
  endtask

  task automatic xfer(input int len, input bit odd, input int stall);
    int idx = 0;
    int need;
    int cyc = 0;
    int left = stall;
    bit got = 0;
    build_model(len, odd, need);
    done_cnt = 0;
    rx_cnt = 0;
    out_cnt = 0;
    start_i = 1;
    len_i = 16'(len);
    odd_i = odd;
    ready_i = 1;
    rx_valid_i = 0;
    step();
    start_i = 0;
    while (!got && cyc < 300) begin
      rx_valid_i = idx < src_q.size();
      rx_data_i = rx_valid_i ? src_q[idx] : 16'h0;
      if (out_cnt > 0 && left > 0) begin
        ready_i = 0;
        left--;
      end else begin
        ready_i = 1;
      end
      step();
      cyc++;
      if (rx_hs) idx++;
      if (done_cnt != 0) got = 1;
    end
    rx_valid_i = 0;
    ready_i = 1;
    repeat (3) step();
    chk("xfer_in_time", 64'(cyc < 300), 1);
    chk("words_left", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("rx_taken", rx_cnt, need);
  endtask

  initial begin
    int n;
    int idx;
    rstn_i = 0;
    clr_i = 0;
    start_i = 0;
    len_i = 0;
    odd_i = 0;
    rx_data_i = 0;
    rx_valid_i = 0;
    ready_i = 1;
    #3;
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rx_ready", rx_ready_o, 0);
    chk("rst_data_be", {data_o, be_o}, 0);
    step();
    step();
    rstn_i = 1;
    step();
    chk("post_rst_busy", busy_o, 0);

    src_q = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
    build_model(8, 0, n);
    chk("pin8_w0", exp_q[0].d, 32'h33221100);
    chk("pin8_w1", exp_q[1].d, 32'h77665544);
    chk("pin8_last", {exp_q[0].l, exp_q[1].l}, 2'b01);
    xfer(8, 0, 0);

    src_q = '{16'haa00, 16'hccbb, 16'hdddd};
    build_model(3, 1, n);
    chk("pin3_w0", exp_q[0].d, 32'h00ccbbaa);
    chk("pin3_be", exp_q[0].be, 4'h7);
    chk("pin3_need", n, 2);
    xfer(3, 1, 0);

    src_q = '{16'h0100, 16'h0302, 16'hee04};
    build_model(5, 0, n);
    chk("pin5_w1", exp_q[1].d, 32'h00000004);
    chk("pin5_be", exp_q[1].be, 4'h1);
    xfer(5, 0, 10);

    src_q = '{16'h2211, 16'h4433, 16'h6655, 16'h8877, 16'ha099};
    xfer(9, 0, 0);
    xfer(7, 1, 3);
    xfer(6, 1, 2);

    rdy_seen = 0;
    vld_seen = 0;
    done_cnt = 0;
    start_i = 1;
    len_i = 0;
    step();
    start_i = 0;
    repeat (4) step();
    chk("len0_done", done_cnt, 1);
    chk("len0_rx_ready", rdy_seen, 0);
    chk("len0_valid", vld_seen, 0);
    chk("len0_busy", busy_o, 0);

    src_q = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
    exp_q.delete();
    idx = 0;
    n = 0;
    ready_i = 0;
    start_i = 1;
    len_i = 8;
    odd_i = 0;
    step();
    start_i = 0;
    while (!valid_o && n < 20) begin
      rx_valid_i = idx < src_q.size();
      rx_data_i = rx_valid_i ? src_q[idx] : 16'h0;
      step();
      n++;
      if (rx_hs) idx++;
    end
    chk("clr_setup_valid", valid_o, 1);
    done_cnt = 0;
    clr_i = 1;
    step();
    clr_i = 0;
    rx_valid_i = 0;
    chk("clr_valid", valid_o, 0);
    chk("clr_busy", busy_o, 0);
    ready_i = 1;
    repeat (3) step();
    chk("clr_no_done", done_cnt, 0);
    src_q = '{16'hb0a0, 16'hd0c0};
    xfer(4, 0, 0);

    src_q = '{16'hbeef};
    exp_q.delete();
    ready_i = 0;
    start_i = 1;
    len_i = 2;
    odd_i = 0;
    step();
    start_i = 0;
    rx_valid_i = 1;
    rx_data_i = 16'hbeef;
    n = 0;
    while (!valid_o && n < 20) begin
      step();
      n++;
      if (rx_hs) rx_valid_i = 0;
    end
    rx_valid_i = 0;
    chk("flush_setup", {valid_o, busy_o}, 2'b11);
    #1 rstn_i = 0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_last", last_o, 0);
    chk("arst_busy_done", {busy_o, done_o}, 0);
    chk("arst_rx_ready", rx_ready_o, 0);
    chk("arst_data_be", {data_o, be_o}, 0);
    step();
    step();
    rstn_i = 1;
    ready_i = 1;
    step();
    chk("arst_idle", busy_o, 0);
    src_q = '{16'h2301, 16'h6745};
    xfer(4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
